// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder
//   Memory-side responder for the LC-3 CS/WE/READY handshake. Holds a
//   word-addressed RAM plus memory-mapped keyboard (KBSR/KBDR) and display
//   (DSR/DDR) registers. Each CS assertion performs one access. That access
//   completes after WAIT_STATES extra cycles and gives a single-cycle READY.
//
// Ports
//   CLK        in   system clock, rising edge
//   RESET      in   asynchronous active-high reset
//   CS         in   access request, held by the initiator until READY
//   WE         in   1 = write, 0 = read, sampled with CS
//   ADDR       in   16-bit word address
//   DATA_IN    in   16-bit write data
//   DATA_OUT   out  registered read data, held until the next completed read
//   READY      out  one-cycle access-complete pulse
//   KB_VALID   in   keyboard character strobe
//   KB_DATA    in   keyboard character
//   DISP_VALID out  one-cycle display write strobe
//   DISP_DATA  out  display character
module lc3_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CS,
  input  logic        WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] DATA_IN,
  output logic [15:0] DATA_OUT,
  output logic        READY,
  input  logic        KB_VALID,
  input  logic [7:0]  KB_DATA,
  output logic        DISP_VALID,
  output logic [7:0]  DISP_DATA
);

  localparam logic [15:0] MMIO_BASE = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  localparam int CNT_W = (WAIT_STATES > 2) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       addr_q;
  logic              we_q;
  logic [15:0]       wdata_q;
  logic [15:0]       data_out_q;
  logic              ready_q;
  logic              disp_valid_q;
  logic [7:0]        disp_data_q;
  logic              kbsr_q;
  logic [7:0]        kbdr_q;

  logic [15:0]       mem [2**ADDR_W];

  logic              capture;
  logic              go_ack;
  logic              commit;
  logic [15:0]       acc_addr;
  logic              acc_we;
  logic [15:0]       acc_wdata;
  logic              is_ram;
  logic [15:0]       rd_val;
  logic              kbdr_rd;
  logic              disp_wr;
  logic              ram_we;

  // Next-state logic. With zero wait states the access commits on the very
  // edge that samples CS, so the access fields come straight from the
  // inputs instead of the capture registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    go_ack    = 1'b0;
    acc_addr  = addr_q;
    acc_we    = we_q;
    acc_wdata = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (CS) begin
          capture   = 1'b1;
          acc_addr  = ADDR;
          acc_we    = WE;
          acc_wdata = DATA_IN;
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
            go_ack  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!CS) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_ACK;
          go_ack  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK: begin
        state_d = CS ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!CS) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Side effects of the access, all taking place on the edge that enters ACK.
  always_comb begin
    commit  = go_ack && !RESET;
    is_ram  = (acc_addr < MMIO_BASE);
    kbdr_rd = commit && !acc_we && (acc_addr == KBDR_ADDR);
    disp_wr = commit && acc_we && (acc_addr == DDR_ADDR);
    ram_we  = commit && acc_we && is_ram;
    rd_val  = '0;
    if (is_ram) begin
      rd_val = mem[acc_addr[ADDR_W-1:0]];
    end else begin
      case (acc_addr)
        KBSR_ADDR: rd_val = {kbsr_q, 15'b0};
        KBDR_ADDR: rd_val = {8'h00, kbdr_q};
        DSR_ADDR:  rd_val = 16'h8000;
        default:   rd_val = '0;
      endcase
    end
  end

  // RAM contents are not reset, so the array lives in its own clocked block.
  always_ff @(posedge CLK) begin
    if (ram_we) begin
      mem[acc_addr[ADDR_W-1:0]] <= acc_wdata;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      data_out_q   <= '0;
      ready_q      <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      kbsr_q       <= 1'b0;
      kbdr_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= commit;
      disp_valid_q <= disp_wr;
      if (capture) begin
        addr_q  <= ADDR;
        we_q    <= WE;
        wdata_q <= DATA_IN;
      end
      if (commit && !acc_we) begin
        data_out_q <= rd_val;
      end
      if (disp_wr) begin
        disp_data_q <= acc_wdata[7:0];
      end
      // A KBDR read on the same edge as a new strobe frees the slot for the
      // new character, so the flag stays set and the read sees the old one.
      if (KB_VALID && (!kbsr_q || kbdr_rd)) begin
        kbdr_q <= KB_DATA;
        kbsr_q <= 1'b1;
      end else if (kbdr_rd) begin
        kbsr_q <= 1'b0;
      end
    end
  end

  assign DATA_OUT   = data_out_q;
  assign READY      = ready_q;
  assign DISP_VALID = disp_valid_q;
  assign DISP_DATA  = disp_data_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: one instance with two wait states,
// one with none; shared address/data/keyboard inputs, separate CS lines.
module tb_lc3_mem_responder;

  localparam int WS     = 2;
  localparam int BUDGET = 20;

  logic        CLK;
  logic        RESET;
  logic        CS2, CS0;
  logic        WE;
  logic [15:0] ADDR, DATA_IN;
  logic        KB_VALID;
  logic [7:0]  KB_DATA;

  logic [15:0] DATA_OUT2, DATA_OUT0;
  logic        READY2, READY0;
  logic        DISP_VALID2, DISP_VALID0;
  logic [7:0]  DISP_DATA2, DISP_DATA0;

  int n_tests = 0;
  int n_fail  = 0;

  lc3_mem_responder #(.ADDR_W(10), .WAIT_STATES(WS)) dut2 (
    .CLK(CLK), .RESET(RESET), .CS(CS2), .WE(WE), .ADDR(ADDR),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT2), .READY(READY2),
    .KB_VALID(KB_VALID), .KB_DATA(KB_DATA),
    .DISP_VALID(DISP_VALID2), .DISP_DATA(DISP_DATA2)
  );

  lc3_mem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .CS(CS0), .WE(WE), .ADDR(ADDR),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT0), .READY(READY0),
    .KB_VALID(KB_VALID), .KB_DATA(KB_DATA),
    .DISP_VALID(DISP_VALID0), .DISP_DATA(DISP_DATA0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One access on the two-wait-state instance. READY must first be seen on
  // the sample following posedge WS+1, counting the capture edge as 1.
  // kbc pulses KB_VALID with kbd only on the commit edge.
  task automatic acc2(input string tag, input logic we_v,
                      input logic [15:0] a, input logic [15:0] d,
                      input logic chk_rd, input logic [15:0] exp_rd,
                      input logic kbc, input logic [7:0] kbd,
                      output logic dv, output logic [7:0] dd);
    int   n;
    logic seen;
    logic dv_early;
    n = 0; seen = 1'b0; dv_early = 1'b0; dv = 1'b0; dd = '0;
    @(negedge CLK);
    WE = we_v; ADDR = a; DATA_IN = d; CS2 = 1'b1;
    for (int i = 1; i <= BUDGET && !seen; i++) begin
      if (kbc && i == WS + 1) begin
        KB_VALID = 1'b1;
        KB_DATA  = kbd;
      end
      @(posedge CLK);
      #1;
      KB_VALID = 1'b0;
      if (READY2) begin
        seen = 1'b1;
        n    = i;
        dv   = DISP_VALID2;
        dd   = DISP_DATA2;
        if (chk_rd) check({tag, "_rd"}, DATA_OUT2, exp_rd);
      end else if (DISP_VALID2) begin
        dv_early = 1'b1;
      end
    end
    check({tag, "_lat"}, 16'(n), 16'(WS + 1));
    check({tag, "_dv_early"}, {15'b0, dv_early}, 16'h0000);
    @(negedge CLK);
    CS2 = 1'b0;
    @(posedge CLK);
    #1;
    check({tag, "_rdy_off"}, {15'b0, READY2}, 16'h0000);
    check({tag, "_dv_off"}, {15'b0, DISP_VALID2}, 16'h0000);
  endtask

  initial begin
    logic       dv;
    logic [7:0] dd;
    int         pulses;

    RESET = 1'b1; CS2 = 1'b0; CS0 = 1'b0; WE = 1'b0;
    ADDR = '0; DATA_IN = '0; KB_VALID = 1'b0; KB_DATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ready", {15'b0, READY2}, 16'h0000);
    check("rst_dout", DATA_OUT2, 16'h0000);
    check("rst_dv", {15'b0, DISP_VALID2}, 16'h0000);
    check("rst_dd", {8'h00, DISP_DATA2}, 16'h0000);
    check("rst_ready0", {15'b0, READY0}, 16'h0000);
    @(negedge CLK);
    RESET = 1'b0;

    // Basic write then read with wait states
    acc2("wr40", 1'b1, 16'h0040, 16'h1234, 1'b0, '0, 1'b0, '0, dv, dd);
    check("dout_hold_wr", DATA_OUT2, 16'h0000);
    acc2("rd40", 1'b0, 16'h0040, '0, 1'b1, 16'h1234, 1'b0, '0, dv, dd);
    // Upper address bits alias onto the same RAM word
    acc2("rd440", 1'b0, 16'h0440, '0, 1'b1, 16'h1234, 1'b0, '0, dv, dd);

    // Abort during WAIT leaves RAM untouched
    acc2("wr10", 1'b1, 16'h0010, 16'h5555, 1'b0, '0, 1'b0, '0, dv, dd);
    @(negedge CLK);
    WE = 1'b1; ADDR = 16'h0010; DATA_IN = 16'hBEEF; CS2 = 1'b1;
    @(negedge CLK);
    CS2 = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(posedge CLK);
      #1;
      if (READY2) pulses++;
    end
    check("abort_no_ready", 16'(pulses), 16'h0000);
    acc2("rd10", 1'b0, 16'h0010, '0, 1'b1, 16'h5555, 1'b0, '0, dv, dd);

    // Zero wait states, CS held past READY
    @(negedge CLK);
    WE = 1'b0; ADDR = 16'hFE04; CS0 = 1'b1;
    @(posedge CLK);
    #1;
    check("ws0_ready", {15'b0, READY0}, 16'h0001);
    check("ws0_dsr", DATA_OUT0, 16'h8000);
    pulses = 0;
    @(negedge CLK);
    ADDR = 16'hFE00;
    repeat (4) begin
      @(posedge CLK);
      #1;
      if (READY0) pulses++;
    end
    check("ws0_hold_pulses", 16'(pulses), 16'h0000);
    @(negedge CLK);
    CS0 = 1'b0;
    @(posedge CLK);
    #1;
    check("ws0_idle_ready", {15'b0, READY0}, 16'h0000);
    @(negedge CLK);
    CS0 = 1'b1;
    @(posedge CLK);
    #1;
    check("ws0_again_ready", {15'b0, READY0}, 16'h0001);
    check("ws0_again_kbsr", DATA_OUT0, 16'h0000);
    @(negedge CLK);
    CS0 = 1'b0;

    // Keyboard
    @(negedge CLK);
    KB_VALID = 1'b1; KB_DATA = 8'h41;
    @(negedge CLK);
    KB_VALID = 1'b0;
    acc2("kbsr_full", 1'b0, 16'hFE00, '0, 1'b1, 16'h8000, 1'b0, '0, dv, dd);
    @(negedge CLK);
    KB_VALID = 1'b1; KB_DATA = 8'h42;
    @(negedge CLK);
    KB_VALID = 1'b0;
    acc2("kbdr_41", 1'b0, 16'hFE02, '0, 1'b1, 16'h0041, 1'b0, '0, dv, dd);
    acc2("kbsr_clr", 1'b0, 16'hFE00, '0, 1'b1, 16'h0000, 1'b0, '0, dv, dd);
    @(negedge CLK);
    KB_VALID = 1'b1; KB_DATA = 8'h43;
    @(negedge CLK);
    KB_VALID = 1'b0;
    acc2("kbdr_coinc", 1'b0, 16'hFE02, '0, 1'b1, 16'h0043, 1'b1, 8'h44, dv, dd);
    acc2("kbsr_still", 1'b0, 16'hFE00, '0, 1'b1, 16'h8000, 1'b0, '0, dv, dd);
    acc2("kbdr_44", 1'b0, 16'hFE02, '0, 1'b1, 16'h0044, 1'b0, '0, dv, dd);
    acc2("kbdr_wr", 1'b1, 16'hFE02, 16'h0099, 1'b0, '0, 1'b0, '0, dv, dd);
    acc2("kbdr_keep", 1'b0, 16'hFE02, '0, 1'b1, 16'h0044, 1'b0, '0, dv, dd);

    // Display and unmapped MMIO
    acc2("ddr_wr", 1'b1, 16'hFE06, 16'h0048, 1'b0, '0, 1'b0, '0, dv, dd);
    check("ddr_dv_ack", {15'b0, dv}, 16'h0001);
    check("ddr_dd_ack", {8'h00, dd}, 16'h0048);
    acc2("dsr_rd", 1'b0, 16'hFE04, '0, 1'b1, 16'h8000, 1'b0, '0, dv, dd);
    check("dsr_dv", {15'b0, dv}, 16'h0000);
    acc2("fe08_rd", 1'b0, 16'hFE08, '0, 1'b1, 16'h0000, 1'b0, '0, dv, dd);
    acc2("ddr_rd", 1'b0, 16'hFE06, '0, 1'b1, 16'h0000, 1'b0, '0, dv, dd);

    // Reset in the middle of a write
    acc2("wr20", 1'b1, 16'h0020, 16'h2222, 1'b0, '0, 1'b0, '0, dv, dd);
    acc2("rd20a", 1'b0, 16'h0020, '0, 1'b1, 16'h2222, 1'b0, '0, dv, dd);
    @(negedge CLK);
    WE = 1'b1; ADDR = 16'h0020; DATA_IN = 16'hDEAD; CS2 = 1'b1;
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check("midrst_ready", {15'b0, READY2}, 16'h0000);
    check("midrst_dout", DATA_OUT2, 16'h0000);
    check("midrst_dd", {8'h00, DISP_DATA2}, 16'h0000);
    @(negedge CLK);
    RESET = 1'b0; CS2 = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(posedge CLK);
      #1;
      if (READY2) pulses++;
    end
    check("midrst_no_ready", 16'(pulses), 16'h0000);
    acc2("rd20b", 1'b0, 16'h0020, '0, 1'b1, 16'h2222, 1'b0, '0, dv, dd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
